// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: N-channel request arbiter in front of one SDRAM
// controller port, with an ID FIFO routing in-order responses back.
module sdram_port_arbiter #(
  parameter int NCH             = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NCH-1:0]                         ch_valid,
  output logic [NCH-1:0]                         ch_ready,
  input  logic [NCH-1:0]                         ch_we,
  input  logic [NCH*ADDR_WIDTH-1:0]              ch_addr,
  input  logic [NCH*DATA_WIDTH-1:0]              ch_wdata,
  input  logic [NCH*(DATA_WIDTH/8)-1:0]          ch_wstrb,
  output logic [NCH-1:0]                         ch_rsp_valid,
  output logic [DATA_WIDTH-1:0]                  ch_rsp_data,
  output logic                                   cmd_valid,
  output logic                                   cmd_we,
  output logic [ADDR_WIDTH-1:0]                  cmd_addr,
  output logic [DATA_WIDTH-1:0]                  cmd_wdata,
  output logic [DATA_WIDTH/8-1:0]                cmd_wstrb,
  input  logic                                   cmd_ready,
  input  logic                                   rsp_valid,
  input  logic [DATA_WIDTH-1:0]                  rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_unexpected_rsp
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_next;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] head;
  logic          gnt_any;
  logic          pop;
  logic          hs;
  logic          slot_free;
  logic          eligible;
  logic [CW-1:0] cnt_after_pop;

  assign pop           = rsp_valid && (outstanding != '0);
  assign slot_free     = !cmd_valid || cmd_ready;
  assign cnt_after_pop = outstanding - CW'(pop);
  assign eligible      = rstn && slot_free &&
                         (cnt_after_pop < CW'(MAX_OUTSTANDING));
  assign hs            = eligible && gnt_any;
  assign head          = fifo_mem[rd_ptr];
  assign rr_next       = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);

  // Pick the winning channel: lowest index, or first at/after rr_ptr.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] c;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    c       = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ARB_MODE != 0) begin
        sum = {1'b0, rr_ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
        c = sum[IW-1:0];
      end else begin
        c = IW'(k);
      end
      if (!gnt_any && ch_valid[c]) begin
        gnt_any = 1'b1;
        gnt_idx = c;
      end
    end
  end

  // One-hot grant to the winner when a command can be taken.
  always_comb begin
    ch_ready = '0;
    if (hs) ch_ready[gnt_idx] = 1'b1;
  end

  // ID FIFO storage; pointers live with the rest of the state.
  always_ff @(posedge clk) begin
    if (hs) fifo_mem[wr_ptr] <= gnt_idx;
  end

  // Command register, FIFO pointers, response routing and counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_valid          <= 1'b0;
      cmd_we             <= 1'b0;
      cmd_addr           <= '0;
      cmd_wdata          <= '0;
      cmd_wstrb          <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      rr_ptr             <= '0;
      ch_rsp_valid       <= '0;
      ch_rsp_data        <= '0;
      outstanding        <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (hs) begin
        cmd_valid <= 1'b1;
        cmd_we    <= ch_we[gnt_idx];
        cmd_addr  <= ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_wdata <= ch_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        cmd_wstrb <= ch_wstrb[gnt_idx*SW +: SW];
        wr_ptr    <= wr_ptr + PW'(1);
        rr_ptr    <= rr_next;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      ch_rsp_valid <= '0;
      if (pop) begin
        rd_ptr             <= rd_ptr + PW'(1);
        ch_rsp_valid[head] <= 1'b1;
        ch_rsp_data        <= rsp_data;
      end
      if (rsp_valid && !pop) err_unexpected_rsp <= 1'b1;
      outstanding <= outstanding + CW'(hs) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed stimulus on a round-robin and a
// fixed-priority instance, checked against a queue-based model.
module tb_sdram_port_arbiter;

  localparam int NCH = 4;
  localparam int MO  = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   ch_valid = '0;
  logic [3:0]   ch_we = '0;
  logic [127:0] ch_addr = '0;
  logic [127:0] ch_wdata = '0;
  logic [15:0]  ch_wstrb = '0;
  logic         cmd_ready = 1'b0;
  logic         rsp_valid = 1'b0;
  logic [31:0]  rsp_data = '0;

  logic [3:0]  o_ready [2];
  logic [3:0]  o_rspv  [2];
  logic [31:0] o_rspd  [2];
  logic        o_cv    [2];
  logic        o_we    [2];
  logic [31:0] o_addr  [2];
  logic [31:0] o_wdata [2];
  logic [3:0]  o_strb  [2];
  logic [2:0]  o_out   [2];
  logic        o_err   [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  bit log_en = 0;
  bit rlog_en = 0;

  int mq [2][$];
  logic        mcv   [2] = '{0, 0};
  logic        mwe   [2] = '{0, 0};
  logic [31:0] maddr [2] = '{0, 0};
  logic [31:0] mwd   [2] = '{0, 0};
  logic [3:0]  mstrb [2] = '{0, 0};
  logic [3:0]  mrv   [2] = '{0, 0};
  logic [31:0] mrd   [2] = '{0, 0};
  logic        merr  [2] = '{0, 0};
  int          mrr   [2] = '{0, 0};

  logic [3:0]  glr [$];
  logic [3:0]  glf [$];
  logic [3:0]  rlr [$];
  logic [31:0] rld [$];

  logic [3:0]  exp_rr [6] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
  logic [3:0]  exp_rs [3] = '{4'd1, 4'd8, 4'd2};
  logic [31:0] exp_rd [3] = '{32'h11, 32'h22, 32'h33};

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NCH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rstn(rstn), .ch_valid(ch_valid), .ch_ready(o_ready[0]),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_wstrb(ch_wstrb), .ch_rsp_valid(o_rspv[0]),
    .ch_rsp_data(o_rspd[0]), .cmd_valid(o_cv[0]), .cmd_we(o_we[0]),
    .cmd_addr(o_addr[0]), .cmd_wdata(o_wdata[0]), .cmd_wstrb(o_strb[0]),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .outstanding(o_out[0]), .err_unexpected_rsp(o_err[0]));

  sdram_port_arbiter #(.NCH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4), .ARB_MODE(0)) u_fp (
    .clk(clk), .rstn(rstn), .ch_valid(ch_valid), .ch_ready(o_ready[1]),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_wstrb(ch_wstrb), .ch_rsp_valid(o_rspv[1]),
    .ch_rsp_data(o_rspd[1]), .cmd_valid(o_cv[1]), .cmd_we(o_we[1]),
    .cmd_addr(o_addr[1]), .cmd_wdata(o_wdata[1]), .cmd_wstrb(o_strb[1]),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .outstanding(o_out[1]), .err_unexpected_rsp(o_err[1]));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: outputs now follow from state; then advance state over the edge.
  task automatic model_cycle();
    int    pop;
    int    g;
    int    idx;
    int    h;
    string p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? "rr" : "fp";
      pop = (rsp_valid && mq[k].size() > 0) ? 1 : 0;
      g = -1;
      if (rstn && (!mcv[k] || cmd_ready) && (mq[k].size() - pop < MO)) begin
        for (int j = 0; j < NCH; j++) begin
          idx = (k == 0) ? (mrr[k] + j) % NCH : j;
          if (g < 0 && ch_valid[idx[1:0]]) g = idx;
        end
      end
      if (chk_en) begin
        chk({p, "_ready"}, 64'(o_ready[k]),
            (g >= 0) ? (64'(1) << g) : 64'(0));
        chk({p, "_cmd_valid"}, 64'(o_cv[k]), 64'(mcv[k]));
        chk({p, "_cmd_we"}, 64'(o_we[k]), 64'(mwe[k]));
        chk({p, "_cmd_addr"}, 64'(o_addr[k]), 64'(maddr[k]));
        chk({p, "_cmd_wdata"}, 64'(o_wdata[k]), 64'(mwd[k]));
        chk({p, "_cmd_wstrb"}, 64'(o_strb[k]), 64'(mstrb[k]));
        chk({p, "_rsp_valid"}, 64'(o_rspv[k]), 64'(mrv[k]));
        chk({p, "_rsp_data"}, 64'(o_rspd[k]), 64'(mrd[k]));
        chk({p, "_outstanding"}, 64'(o_out[k]), 64'(mq[k].size()));
        chk({p, "_err"}, 64'(o_err[k]), 64'(merr[k]));
        if (log_en && o_ready[k] != 0) begin
          if (k == 0) glr.push_back(o_ready[0]);
          else glf.push_back(o_ready[1]);
        end
        if (rlog_en && k == 0 && o_rspv[0] != 0) begin
          rlr.push_back(o_rspv[0]);
          rld.push_back(o_rspd[0]);
        end
      end
      if (!rstn) begin
        mq[k].delete();
        mcv[k] = 0; mwe[k] = 0; maddr[k] = '0; mwd[k] = '0;
        mstrb[k] = '0; mrv[k] = '0; mrd[k] = '0; merr[k] = 0;
        mrr[k] = 0;
      end else begin
        mrv[k] = '0;
        if (rsp_valid) begin
          if (mq[k].size() > 0) begin
            h = mq[k].pop_front();
            mrv[k] = 4'(1 << h);
            mrd[k] = rsp_data;
          end else begin
            merr[k] = 1;
          end
        end
        if (g >= 0) begin
          mcv[k]   = 1;
          mwe[k]   = ch_we[g[1:0]];
          maddr[k] = ch_addr[g*32 +: 32];
          mwd[k]   = ch_wdata[g*32 +: 32];
          mstrb[k] = ch_wstrb[g*4 +: 4];
          mq[k].push_back(g);
          mrr[k] = (g + 1) % NCH;
        end else if (cmd_ready) begin
          mcv[k] = 0;
        end
      end
    end
  endtask

  always @(negedge clk) model_cycle();

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    tick(1);
    rstn = 1;

    // Single read on ch2, response three cycles after acceptance.
    ch_addr[64 +: 32] = 32'h2000_0040;
    ch_valid = 4'b0100;
    cmd_ready = 1;
    @(negedge clk);
    chk("t1_grant", 64'(o_ready[0]), 64'h4);
    chk("t1_outst0", 64'(o_out[0]), 64'd0);
    tick(1);
    ch_valid = 0;
    @(negedge clk);
    chk("t1_cmd_valid", 64'(o_cv[0]), 64'd1);
    chk("t1_cmd_addr", 64'(o_addr[0]), 64'h2000_0040);
    chk("t1_outst1", 64'(o_out[0]), 64'd1);
    tick(3);
    rsp_valid = 1;
    rsp_data = 32'hDEAD_BEEF;
    tick(1);
    rsp_valid = 0;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(o_rspv[0]), 64'h4);
    chk("t1_rsp_data", 64'(o_rspd[0]), 64'hDEAD_BEEF);
    chk("t1_outst_end", 64'(o_out[0]), 64'd0);
    tick(1);

    // All four channels requesting: rotation vs lowest-index.
    rstn = 0;
    tick(1);
    rstn = 1;
    ch_addr = {32'h3000_000C, 32'h3000_0008, 32'h3000_0004, 32'h3000_0000};
    ch_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    ch_wstrb = 16'h8421;
    glr.delete();
    glf.delete();
    rsp_data = 32'h1234_5678;
    ch_valid = 4'hF;
    log_en = 1;
    tick(1);
    rsp_valid = 1;
    tick(5);
    log_en = 0;
    ch_valid = 0;
    tick(1);
    rsp_valid = 0;
    tick(1);
    chk("t2_rr_count", 64'(glr.size()), 64'd6);
    chk("t2_fp_count", 64'(glf.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_rr_order%0d", i), 64'(glr[i]), 64'(exp_rr[i]));
      chk($sformatf("t2_fp_order%0d", i), 64'(glf[i]), 64'h1);
    end

    // Six reads from ch1 with no responses: FIFO fills at four.
    glr.delete();
    glf.delete();
    ch_valid = 4'b0010;
    log_en = 1;
    tick(6);
    log_en = 0;
    chk("t3_rr_grants", 64'(glr.size()), 64'd4);
    chk("t3_fp_grants", 64'(glf.size()), 64'd4);
    @(negedge clk);
    chk("t3_full_outst", 64'(o_out[0]), 64'd4);
    chk("t3_full_ready", 64'(o_ready[0]), 64'd0);
    tick(1);
    rsp_valid = 1;
    @(negedge clk);
    chk("t3_pop_regrant", 64'(o_ready[0]), 64'h2);
    tick(1);
    ch_valid = 0;
    @(negedge clk);
    chk("t3_outst_again", 64'(o_out[0]), 64'd4);
    tick(4);
    rsp_valid = 0;
    tick(1);

    // Write to 0x100 stalled by the controller for five cycles.
    ch_we = 4'b0001;
    ch_addr[0 +: 32] = 32'h100;
    ch_wdata[0 +: 32] = 32'hCAFE_F00D;
    ch_wstrb[0 +: 4] = 4'hF;
    ch_valid = 4'b0001;
    cmd_ready = 0;
    @(negedge clk);
    chk("t4_grant", 64'(o_ready[0]), 64'h1);
    tick(1);
    ch_addr[0 +: 32] = 32'h200;
    ch_wdata[0 +: 32] = 32'h5555_AAAA;
    ch_wstrb[0 +: 4] = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_addr%0d", i), 64'(o_addr[0]), 64'h100);
      chk($sformatf("t4_wdata%0d", i), 64'(o_wdata[0]), 64'hCAFE_F00D);
      chk($sformatf("t4_wstrb%0d", i), 64'(o_strb[0]), 64'hF);
      chk($sformatf("t4_noready%0d", i), 64'(o_ready[0]), 64'd0);
      tick(1);
    end
    cmd_ready = 1;
    @(negedge clk);
    chk("t4_accept_grant", 64'(o_ready[0]), 64'h1);
    tick(1);
    ch_valid = 0;
    @(negedge clk);
    chk("t4_next_addr", 64'(o_addr[0]), 64'h200);
    tick(1);
    rsp_valid = 1;
    tick(2);
    rsp_valid = 0;
    tick(1);

    // Mixed traffic: ch0 write, ch3 read, ch1 read; in-order responses.
    rlr.delete();
    rld.delete();
    rlog_en = 1;
    ch_addr = {32'h4000_0030, 32'h4000_0020, 32'h4000_0010, 32'h4000_0000};
    ch_valid = 4'b0001;
    tick(1);
    ch_valid = 4'b1000;
    tick(1);
    ch_valid = 4'b0010;
    tick(1);
    ch_valid = 0;
    tick(1);
    rsp_valid = 1;
    rsp_data = 32'h11;
    tick(1);
    rsp_data = 32'h22;
    tick(1);
    rsp_data = 32'h33;
    tick(1);
    rsp_valid = 0;
    tick(2);
    rlog_en = 0;
    chk("t5_rsp_count", 64'(rlr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_rsp_ch%0d", i), 64'(rlr[i]), 64'(exp_rs[i]));
      chk($sformatf("t5_rsp_data%0d", i), 64'(rld[i]), 64'(exp_rd[i]));
    end

    // Stray response, then a one-cycle reset.
    rsp_valid = 1;
    rsp_data = 32'h99;
    tick(1);
    rsp_valid = 0;
    @(negedge clk);
    chk("t6_err_rr", 64'(o_err[0]), 64'd1);
    chk("t6_err_fp", 64'(o_err[1]), 64'd1);
    chk("t6_no_rsp", 64'(o_rspv[0]), 64'd0);
    tick(1);
    rstn = 0;
    ch_valid = 4'hF;
    @(negedge clk);
    chk("t6_rst_ready", 64'(o_ready[0]), 64'd0);
    tick(1);
    rstn = 1;
    ch_valid = 0;
    @(negedge clk);
    chk("t6_rst_cv", 64'(o_cv[0]), 64'd0);
    chk("t6_rst_addr", 64'(o_addr[0]), 64'd0);
    chk("t6_rst_wdata", 64'(o_wdata[0]), 64'd0);
    chk("t6_rst_rspv", 64'(o_rspv[0]), 64'd0);
    chk("t6_rst_rspd", 64'(o_rspd[0]), 64'd0);
    chk("t6_rst_outst", 64'(o_out[0]), 64'd0);
    chk("t6_rst_err", 64'(o_err[0]), 64'd0);
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
